// File: rtl/pea_fifo_pkg.sv
// Shared definitions for the PEA FIFOs: default token/buffer sizes,
// the pointer-width helper and the per-cycle operation encoding.
package pea_fifo_pkg;

   localparam int default_word_size   = 16;
   localparam int default_buffer_size = 1024;

   // Floor of log2; callers only pass powers of two, so this is exact.
   function automatic int log2(input int value);
      int result;
      result = 0;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) <= value) result = i;
      end
      return result;
   endfunction

   typedef enum logic [1:0] {
      op_idle,
      op_write,
      op_read,
      op_both
   } fifo_op_e;

endpackage

// File: rtl/pea_fifo_ram.sv
// Simple dual-port RAM: synchronous write, synchronous registered read.
// The read register holds its value unless a read is requested.
module pea_fifo_ram
   import pea_fifo_pkg::*;
#(
   parameter int word_size   = default_word_size,
   parameter int buffer_size = default_buffer_size
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [log2(buffer_size)-1:0] wr_addr,
   input  logic [word_size-1:0]         wr_data,
   input  logic                         rd_en,
   input  logic [log2(buffer_size)-1:0] rd_addr,
   output logic [word_size-1:0]         rd_data
);

   logic [word_size-1:0] mem [buffer_size];

   // NOTE: the storage array has no reset so it maps onto block RAM;
   // stale words are never visible because the pointers gate every read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/pea_fifo.sv
// Synchronous FIFO for the PEA token streams. Capacity is buffer_size-1
// so population always fits in log2(buffer_size) bits.
module pea_fifo
   import pea_fifo_pkg::*;
#(
   parameter int word_size   = default_word_size,
   parameter int buffer_size = default_buffer_size
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [word_size-1:0]         data_in,
   input  logic                         rd_en,
   output logic [word_size-1:0]         data_out,
   output logic [log2(buffer_size)-1:0] population,
   output logic [log2(buffer_size)-1:0] free_space,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int pw = log2(buffer_size);

   logic [pw-1:0] wr_ptr;
   logic [pw-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          rd_ok;
   logic          wr_ok;
   fifo_op_e      op;

   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      full  = (free_space == '0);
      empty = (population == '0);
      rd_ok = rd_en && !empty;
      // A full FIFO still takes a write when a read frees a slot this edge.
      wr_ok = wr_en && (!full || rd_ok);
      op    = op_idle;
      case ({wr_ok, rd_ok})
         2'b10:   op = op_write;
         2'b01:   op = op_read;
         2'b11:   op = op_both;
         default: op = op_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         population <= '0;
         free_space <= pw'(buffer_size - 1);
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + pw'(1);
         if (rd_ok) rd_ptr <= rd_ptr + pw'(1);
         case (op)
            op_write: begin
               population <= population + pw'(1);
               free_space <= free_space - pw'(1);
            end
            op_read: begin
               population <= population - pw'(1);
               free_space <= free_space + pw'(1);
            end
            default: ;
         endcase
         if (wr_en && !wr_ok)  overflow  <= 1'b1;
         if (rd_en && empty)   underflow <= 1'b1;
      end
   end

   // Write and read addresses never collide: when full the write slot is
   // one behind rd_ptr, and when empty the read is suppressed.
   pea_fifo_ram #(
      .word_size   (word_size),
      .buffer_size (buffer_size)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok && !rst),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_en   (rd_ok),
      .rd_addr (rd_ptr),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_pea_fifo.sv
// Randomised and directed bench for pea_fifo with a queue-based reference
// model; a monitor process compares every cycle against the scoreboard.
module tb_pea_fifo;

   localparam int ws  = 16;
   localparam int bs  = 8;
   localparam int cap = bs - 1;

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic [ws-1:0] data_in;
   logic          rd_en;
   logic [ws-1:0] data_out;
   logic [2:0]    population;
   logic [2:0]    free_space;
   logic          overflow;
   logic          underflow;

   pea_fifo #(.word_size(ws), .buffer_size(bs)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .data_in    (data_in),
      .rd_en      (rd_en),
      .data_out   (data_out),
      .population (population),
      .free_space (free_space),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a plain queue of tokens plus the visible registers.
   logic [ws-1:0] m_q [$];
   logic [ws-1:0] m_dout = '0;
   bit            m_ov = 1'b0;
   bit            m_un = 1'b0;
   bit            m_wr_ok = 1'b0;

   task automatic model_step(input bit r, input bit w, input logic [ws-1:0] d, input bit rd);
      bit rd_ok;
      m_wr_ok = 1'b0;
      if (r) begin
         m_q.delete();
         m_dout = '0;
         m_ov   = 1'b0;
         m_un   = 1'b0;
      end else begin
         rd_ok   = rd && (m_q.size() > 0);
         m_wr_ok = w && ((m_q.size() < cap) || rd_ok);
         if (rd && m_q.size() == 0) m_un = 1'b1;
         if (w && !m_wr_ok)         m_ov = 1'b1;
         if (rd_ok)                 m_dout = m_q.pop_front();
         if (m_wr_ok)               m_q.push_back(d);
      end
   endtask

   typedef struct {
      int            tgt;
      logic [ws-1:0] dout;
      int            pop;
      bit            ov;
      bit            un;
   } exp_t;

   exp_t exp_q [$];
   bit   mon_on = 1'b0;

   // Called just after a rising edge: applies inputs for the next edge,
   // records the expected post-edge state, then advances one cycle.
   task automatic drive(input bit r, input bit w, input logic [ws-1:0] d, input bit rd);
      exp_t e;
      rst     = r;
      wr_en   = w;
      data_in = d;
      rd_en   = rd;
      model_step(r, w, d, rd);
      e.tgt  = cyc + 1;
      e.dout = m_dout;
      e.pop  = m_q.size();
      e.ov   = m_ov;
      e.un   = m_un;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_on)
            check("invariant", int'(population) + int'(free_space), cap);
         while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
            e = exp_q.pop_front();
            check("sb_data_out",   data_out,   e.dout);
            check("sb_population", population, e.pop);
            check("sb_free_space", free_space, cap - e.pop);
            check("sb_overflow",   overflow,   e.ov);
            check("sb_underflow",  underflow,  e.un);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [ws-1:0] want [7];
      int written;
      bit w;
      bit r;

      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      @(posedge clk);
      #1;

      // Reset state
      drive(1, 0, '0, 0);
      mon_on = 1'b1;
      check("rst_population", population, 0);
      check("rst_free_space", free_space, 7);
      check("rst_data_out",   data_out,   0);
      check("rst_flags",      {overflow, underflow}, 0);

      // Fill to capacity
      for (int i = 1; i <= 7; i++) drive(0, 1, ws'(i), 0);
      check("fill_population", population, 7);
      check("fill_free_space", free_space, 0);
      check("fill_overflow",   overflow,   0);

      // Write while full without a read is dropped
      drive(0, 1, 16'h00FF, 0);
      check("ovf_flag",       overflow,   1);
      check("ovf_population", population, 7);

      for (int i = 1; i <= 7; i++) begin
         drive(0, 0, '0, 1);
         check("drain_order", data_out, i);
      end

      // Read while empty is dropped and data_out holds
      drive(0, 0, '0, 1);
      check("udf_flag",       underflow,  1);
      check("udf_data_out",   data_out,   16'h0007);
      check("udf_population", population, 0);

      // Simultaneous read and write while full
      for (int i = 1; i <= 7; i++) drive(0, 1, ws'(i), 0);
      drive(0, 1, 16'h1234, 1);
      check("both_data_out",   data_out,   16'h0001);
      check("both_population", population, 7);
      want = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h1234};
      for (int i = 0; i < 7; i++) begin
         drive(0, 0, '0, 1);
         check("both_order", data_out, want[i]);
      end
      check("both_sticky", {overflow, underflow}, 2'b11);

      // Random stream of 20 words across pointer wrap
      drive(1, 0, '0, 0);
      written = 0;
      for (int k = 0; k < 400 && !(written == 20 && m_q.size() == 0); k++) begin
         w = (written < 20) && ($urandom_range(0, 9) < 6);
         r = ($urandom_range(0, 9) < 5);
         drive(0, w, ws'($urandom), r);
         if (m_wr_ok) written++;
      end
      check("stream_written", written, 20);
      check("stream_drained", population, 0);

      // Reset mid-stream with a concurrent write
      drive(1, 0, '0, 0);
      for (int i = 0; i < 5; i++) drive(0, 1, ws'(16'hA0 + i), 0);
      check("pre_rst_population", population, 5);
      drive(1, 1, 16'hBEEF, 0);
      check("mid_rst_population", population, 0);
      check("mid_rst_free_space", free_space, 7);
      check("mid_rst_flags",      {overflow, underflow}, 0);
      drive(0, 0, '0, 1);
      check("mid_rst_underflow",  underflow, 1);
      check("mid_rst_data_out",   data_out,  0);

      drive(0, 0, '0, 0);
      drive(0, 0, '0, 0);
      @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pea_fifo.md
PEA_FIFO -- requirements
Module: pea_fifo

Interface
REQ-001 Parameter word_size, default 16, bit width of each stored token.
REQ-002 Parameter buffer_size, default 1024, number of RAM words; must be a power of two and at least 4.
REQ-003 Localparam pw = log2(buffer_size), width of pointers and counts (10 for 1024).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  write request from the producer (host or PEA output side).
REQ-007 data_in  input  word_size  token to write.
REQ-008 rd_en  input  1  read request from the consumer (PEA input side).
REQ-009 data_out  output  word_size  most recently read token, registered.
REQ-010 population  output  pw  number of stored words, registered.
REQ-011 free_space  output  pw  remaining writable words, registered.
REQ-012 overflow  output  1  sticky flag: a write was rejected because the FIFO was full.
REQ-013 underflow  output  1  sticky flag: a read was rejected because the FIFO was empty.

Function
REQ-014 Usable capacity SHALL be buffer_size-1 words, so population always fits pw bits.
REQ-015 The FIFO SHALL maintain the invariant population + free_space == buffer_size-1 on every cycle.
REQ-016 A write SHALL occur when wr_en=1 and the FIFO is not full.
- data_in is stored at wr_ptr.
- wr_ptr increments modulo buffer_size.
REQ-017 A read SHALL occur when rd_en=1 and population>0.
- data_out takes mem[rd_ptr] on that edge, giving 1-cycle latency.
- rd_ptr increments modulo buffer_size.
REQ-018 data_out SHALL hold its value on all cycles without an accepted read.
REQ-019 population SHALL change by:
- +1 on a write only;
- -1 on a read only;
- 0 on both or neither.
REQ-020 free_space SHALL change by the opposite amount to population under the same conditions.
REQ-021 Full (population == buffer_size-1) with wr_en and rd_en both 1: both operations SHALL occur and population stays unchanged.
REQ-022 Full with wr_en=1 and rd_en=0: the write SHALL be dropped, memory unchanged, overflow set to 1.
REQ-023 Empty with rd_en=1: the read SHALL be dropped, data_out holds, underflow set to 1.
- If wr_en is also 1, the write still occurs (no fall-through).
REQ-024 overflow and underflow SHALL remain 1 until rst.
REQ-025 Pointer wrap from buffer_size-1 to 0 SHALL be seamless, with no lost or duplicated words.
REQ-026 Tokens SHALL be read in exactly the order written.

Reset
REQ-027 On rst=1 at a clock edge the FIFO SHALL set:
- wr_ptr=0, rd_ptr=0, population=0;
- free_space=buffer_size-1;
- data_out=0, overflow=0, underflow=0.
REQ-028 rst SHALL take priority over wr_en and rd_en in the same cycle.
REQ-029 Reset mid-stream SHALL discard all contents logically; RAM contents need not be cleared.
REQ-030 The first cycle after reset release SHALL accept writes.

Structure
REQ-031 The log2 function and default word_size/buffer_size SHALL live in the shared pea_defs include, used by the PEA top level and every FIFO instance.
REQ-032 Storage SHALL be a sub-module pea_fifo_ram:
- simple dual-port, synchronous write, synchronous read;
- parameterized by word_size and buffer_size.
REQ-033 The four PEA FIFOs (control, data, result, status) SHALL be instances of pea_fifo; result uses word_size doubled.

Verification (bench buffer_size=8, word_size=16)
REQ-034 Reset, then write 0x0001..0x0007 -> population=7, free_space=0, overflow=0.
REQ-035 Full, then wr_en with 0x00FF and no read -> overflow=1, population=7; subsequent reads return 0x0001..0x0007 in order and 0x00FF never appears.
REQ-036 Empty, then rd_en=1 -> underflow=1, data_out holds last value 0x0007, population=0.
REQ-037 Full, then wr_en and rd_en together with 0x1234 -> data_out=0x0001 next cycle, population stays 7, 0x1234 is read last.
REQ-038 Stream 20 words with random wr_en/rd_en across pointer wrap -> scoreboard order exact, and population+free_space==7 on every cycle.
REQ-039 rst asserted while population=5 and wr_en=1 -> next cycle population=0, free_space=7, flags clear, next read underflows.
